kudu_perf_ctrl: RTL and testbench

KUDU_PERF_CTRL -- requirements
Module: kudu_perf_ctrl

---
 rtl/kudu_perf_pkg.sv | 22 ++
 rtl/kudu_perf_cnt.sv | 54 +++++
 rtl/kudu_perf_ctrl.sv | 125 ++++++++++++
 tb/tb_kudu_perf_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kudu_perf_pkg.sv
// Shared types and default sizing for the kudu performance-counter controller.
package kudu_perf_pkg;

  localparam int unsigned NUM_EVENTS_DEF = 16;
  localparam int unsigned NUM_CNT_DEF    = 4;
  localparam int unsigned CNT_W_DEF      = 32;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_CLEAR = 2'd2,
    CMD_DUMP  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_RUNNING,
    ST_DUMP_STOPPED,
    ST_DUMP_RUNNING
  } perf_state_e;

endpackage

// File: rtl/kudu_perf_cnt.sv
// One programmable saturating event counter: event select register, clear and
// sticky overflow flag.
module kudu_perf_cnt #(
  parameter int unsigned NumEvents = 16,
  parameter int unsigned CntW      = 32,
  parameter int unsigned RstSel    = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         clr_i,
  input  logic [NumEvents-1:0]         event_i,
  input  logic                         cfg_we_i,
  input  logic [$clog2(NumEvents)-1:0] cfg_sel_i,
  output logic [CntW-1:0]              cnt_o,
  output logic                         ovf_o
);

  localparam int unsigned SelW = $clog2(NumEvents);

  logic [SelW-1:0] sel_q;
  logic [CntW-1:0] cnt_q;
  logic            ovf_q;

  // The select register updates independently so the write cycle still counts
  // with the old selection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q <= SelW'(RstSel);
    end else if (cfg_we_i) begin
      sel_q <= cfg_sel_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (en_i && event_i[sel_q]) begin
      if (&cnt_q) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/kudu_perf_ctrl.sv
// Performance-counter controller: start/stop/clear/dump command FSM over a bank
// of saturating counters, with a snapshot readout stream.
module kudu_perf_ctrl
  import kudu_perf_pkg::*;
#(
  parameter int unsigned NumEvents = NUM_EVENTS_DEF,
  parameter int unsigned NumCnt    = NUM_CNT_DEF,
  parameter int unsigned CntW      = CNT_W_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumEvents-1:0]         event_i,
  input  logic                         cmd_valid_i,
  input  logic [1:0]                   cmd_op_i,
  output logic                         cmd_ready_o,
  input  logic                         cfg_we_i,
  input  logic [$clog2(NumCnt)-1:0]    cfg_idx_i,
  input  logic [$clog2(NumEvents)-1:0] cfg_sel_i,
  output logic                         running_o,
  output logic                         dump_valid_o,
  input  logic                         dump_ready_i,
  output logic [$clog2(NumCnt)-1:0]    dump_idx_o,
  output logic [CntW-1:0]              dump_data_o,
  output logic                         dump_ovf_o,
  output logic                         dump_last_o
);

  localparam int unsigned IdxW = $clog2(NumCnt);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumCnt - 1);

  perf_state_e     state_q;
  logic [IdxW-1:0] dump_idx_q;
  cmd_op_e         op;
  logic            cmd_fire;
  logic            cmd_clear;
  logic            cmd_dump;

  logic [CntW-1:0]   cnt        [NumCnt];
  logic [NumCnt-1:0] ovf;
  logic [CntW-1:0]   shadow_cnt_q [NumCnt];
  logic [NumCnt-1:0] shadow_ovf_q;

  assign op          = cmd_op_e'(cmd_op_i);
  assign cmd_ready_o = (state_q == ST_STOPPED) || (state_q == ST_RUNNING);
  assign running_o   = (state_q == ST_RUNNING) || (state_q == ST_DUMP_RUNNING);
  assign dump_valid_o = (state_q == ST_DUMP_STOPPED) || (state_q == ST_DUMP_RUNNING);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign cmd_clear   = cmd_fire && (op == CMD_CLEAR);
  assign cmd_dump    = cmd_fire && (op == CMD_DUMP);

  for (genvar k = 0; k < NumCnt; k++) begin : g_cnt
    kudu_perf_cnt #(
      .NumEvents (NumEvents),
      .CntW      (CntW),
      .RstSel    (k % NumEvents)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (running_o),
      .clr_i     (cmd_clear),
      .event_i   (event_i),
      .cfg_we_i  (cfg_we_i && (cfg_idx_i == IdxW'(k))),
      .cfg_sel_i (cfg_sel_i),
      .cnt_o     (cnt[k]),
      .ovf_o     (ovf[k])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NumCnt; k++) begin
        shadow_cnt_q[k] <= '0;
      end
      shadow_ovf_q <= '0;
    end else if (cmd_dump) begin
      for (int unsigned k = 0; k < NumCnt; k++) begin
        shadow_cnt_q[k] <= cnt[k];
      end
      shadow_ovf_q <= ovf;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_STOPPED;
      dump_idx_q <= '0;
    end else begin
      unique case (state_q)
        ST_STOPPED: begin
          if (cmd_fire && op == CMD_START) begin
            state_q <= ST_RUNNING;
          end else if (cmd_fire && op == CMD_DUMP) begin
            state_q    <= ST_DUMP_STOPPED;
            dump_idx_q <= '0;
          end
        end
        ST_RUNNING: begin
          if (cmd_fire && op == CMD_STOP) begin
            state_q <= ST_STOPPED;
          end else if (cmd_fire && op == CMD_DUMP) begin
            state_q    <= ST_DUMP_RUNNING;
            dump_idx_q <= '0;
          end
        end
        ST_DUMP_STOPPED, ST_DUMP_RUNNING: begin
          if (dump_ready_i) begin
            if (dump_idx_q == LastIdx) begin
              dump_idx_q <= '0;
              state_q    <= (state_q == ST_DUMP_RUNNING) ? ST_RUNNING : ST_STOPPED;
            end else begin
              dump_idx_q <= dump_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_STOPPED;
      endcase
    end
  end

  assign dump_idx_o  = dump_idx_q;
  assign dump_data_o = dump_valid_o ? shadow_cnt_q[dump_idx_q] : '0;
  assign dump_ovf_o  = dump_valid_o && shadow_ovf_q[dump_idx_q];
  assign dump_last_o = dump_valid_o && (dump_idx_q == LastIdx);

endmodule

// File: tb/tb_kudu_perf_ctrl.sv
// Directed bench for kudu_perf_ctrl: a per-cycle vector table plus hand-written
// multi-cycle sequences; a CntW=4 instance shares the stimulus for saturation.
module tb_kudu_perf_ctrl;
  import kudu_perf_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] event_i;
  logic        cmd_valid_i;
  logic [1:0]  cmd_op_i;
  logic        cfg_we_i;
  logic [1:0]  cfg_idx_i;
  logic [3:0]  cfg_sel_i;
  logic        dump_ready_i;

  logic        cmd_ready_o, running_o, dump_valid_o, dump_ovf_o, dump_last_o;
  logic [1:0]  dump_idx_o;
  logic [31:0] dump_data_o;

  logic        s_cmd_ready_o, s_running_o, s_dump_valid_o, s_dump_ovf_o, s_dump_last_o;
  logic [1:0]  s_dump_idx_o;
  logic [3:0]  s_dump_data_o;

  always #5 clk_i = ~clk_i;

  kudu_perf_ctrl #(.NumEvents(16), .NumCnt(4), .CntW(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .event_i(event_i),
    .cmd_valid_i(cmd_valid_i), .cmd_op_i(cmd_op_i), .cmd_ready_o(cmd_ready_o),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_sel_i(cfg_sel_i),
    .running_o(running_o), .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_idx_o(dump_idx_o), .dump_data_o(dump_data_o), .dump_ovf_o(dump_ovf_o),
    .dump_last_o(dump_last_o)
  );

  kudu_perf_ctrl #(.NumEvents(16), .NumCnt(4), .CntW(4)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .event_i(event_i),
    .cmd_valid_i(cmd_valid_i), .cmd_op_i(cmd_op_i), .cmd_ready_o(s_cmd_ready_o),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_sel_i(cfg_sel_i),
    .running_o(s_running_o), .dump_valid_o(s_dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_idx_o(s_dump_idx_o), .dump_data_o(s_dump_data_o), .dump_ovf_o(s_dump_ovf_o),
    .dump_last_o(s_dump_last_o)
  );

  typedef struct {
    logic        cv;
    logic [1:0]  op;
    logic        we;
    logic [1:0]  widx;
    logic [3:0]  wsel;
    logic [15:0] ev;
    logic        rdy;
    logic        e_ready;
    logic        e_run;
    logic        e_dv;
    logic [1:0]  e_idx;
    logic [31:0] e_data;
    logic        e_last;
  } vec_t;

  vec_t tbl [16];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(input logic cv, input logic [1:0] op, input logic we,
                              input logic [1:0] widx, input logic [3:0] wsel,
                              input logic [15:0] ev, input logic rdy,
                              input logic er, input logic eu, input logic ed,
                              input logic [1:0] ei, input logic [31:0] edat,
                              input logic el);
    vec_t v;
    v.cv = cv; v.op = op; v.we = we; v.widx = widx; v.wsel = wsel; v.ev = ev;
    v.rdy = rdy; v.e_ready = er; v.e_run = eu; v.e_dv = ed; v.e_idx = ei;
    v.e_data = edat; v.e_last = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    event_i = '0; cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cfg_we_i = 1'b0;
    cfg_idx_i = '0; cfg_sel_i = '0; dump_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic cmd(input cmd_op_e op);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic chk_beat(input string name, input logic [1:0] idx,
                          input logic [31:0] data, input logic last);
    chk({name, "_valid"}, dump_valid_o, 1'b1);
    chk({name, "_idx"}, dump_idx_o, idx);
    chk({name, "_data"}, dump_data_o, data);
    chk({name, "_last"}, dump_last_o, last);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //         cv op         we idx sel ev        rdy | rdy run dv idx data last
    tbl[0]  = mk(0, CMD_START, 1, 0, 3, 16'h0000, 0,   1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, CMD_START, 0, 0, 0, 16'h0008, 0,   1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, CMD_START, 0, 0, 0, 16'h0000, 0,   1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, CMD_START, 0, 0, 0, 16'h000A, 0,   1, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, CMD_START, 0, 0, 0, 16'h0004, 0,   1, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, CMD_START, 1, 1, 3, 16'h0008, 0,   1, 1, 0, 0, 0, 0);
    tbl[6]  = mk(0, CMD_START, 0, 0, 0, 16'h0008, 0,   1, 1, 0, 0, 0, 0);
    tbl[7]  = mk(1, CMD_STOP,  0, 0, 0, 16'h0008, 0,   1, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, CMD_START, 0, 0, 0, 16'h0008, 0,   1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, CMD_DUMP,  0, 0, 0, 16'h0000, 0,   0, 0, 1, 0, 4, 0);
    tbl[10] = mk(0, CMD_START, 0, 0, 0, 16'h0000, 0,   0, 0, 1, 0, 4, 0);
    tbl[11] = mk(0, CMD_START, 0, 0, 0, 16'h0000, 1,   0, 0, 1, 1, 3, 0);
    tbl[12] = mk(0, CMD_START, 0, 0, 0, 16'h0000, 1,   0, 0, 1, 2, 1, 0);
    tbl[13] = mk(1, CMD_START, 0, 0, 0, 16'h0000, 1,   0, 0, 1, 3, 4, 1);
    tbl[14] = mk(1, CMD_START, 0, 0, 0, 16'h0000, 1,   1, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, CMD_START, 0, 0, 0, 16'h0000, 0,   1, 1, 0, 0, 0, 0);

    do_reset();
    chk("rst_ready", cmd_ready_o, 1'b1);
    chk("rst_running", running_o, 1'b0);
    chk("rst_dump_valid", dump_valid_o, 1'b0);
    chk("rst_dump_last", dump_last_o, 1'b0);
    chk("rst_dump_idx", dump_idx_o, 2'd0);
    chk("rst_dump_data", dump_data_o, 32'd0);
    chk("rst_dump_ovf", dump_ovf_o, 1'b0);

    for (int i = 0; i < 16; i++) begin
      cmd_valid_i = tbl[i].cv; cmd_op_i = tbl[i].op; cfg_we_i = tbl[i].we;
      cfg_idx_i = tbl[i].widx; cfg_sel_i = tbl[i].wsel; event_i = tbl[i].ev;
      dump_ready_i = tbl[i].rdy;
      step();
      chk($sformatf("row%0d_ready", i), cmd_ready_o, tbl[i].e_ready);
      chk($sformatf("row%0d_running", i), running_o, tbl[i].e_run);
      chk($sformatf("row%0d_valid", i), dump_valid_o, tbl[i].e_dv);
      chk($sformatf("row%0d_idx", i), dump_idx_o, tbl[i].e_idx);
      chk($sformatf("row%0d_data", i), dump_data_o, tbl[i].e_data);
      chk($sformatf("row%0d_last", i), dump_last_o, tbl[i].e_last);
      chk($sformatf("row%0d_ovf", i), dump_ovf_o, 1'b0);
    end
    idle();

    // Basic count then consecutive dump beats.
    begin
      logic [31:0] exp_b [4];
      exp_b[0] = 10; exp_b[1] = 0; exp_b[2] = 0; exp_b[3] = 10;
      do_reset();
      cfg_we_i = 1'b1; cfg_idx_i = 2'd0; cfg_sel_i = 4'd3;
      step();
      cfg_we_i = 1'b0;
      cmd(CMD_START);
      event_i = 16'h0008;
      repeat (10) step();
      event_i = '0;
      cmd(CMD_STOP);
      dump_ready_i = 1'b1;
      cmd(CMD_DUMP);
      for (int k = 0; k < 4; k++) begin
        chk_beat($sformatf("basic_beat%0d", k), 2'(k), exp_b[k], k == 3);
        step();
      end
      chk("basic_end_valid", dump_valid_o, 1'b0);
      chk("basic_end_ready", cmd_ready_o, 1'b1);
      idle();
    end

    // Saturation on the 4-bit instance, then clear.
    do_reset();
    cmd(CMD_START);
    event_i = 16'h0001;
    repeat (20) step();
    event_i = '0;
    cmd(CMD_STOP);
    dump_ready_i = 1'b1;
    cmd(CMD_DUMP);
    chk("sat_data", s_dump_data_o, 4'hF);
    chk("sat_ovf", s_dump_ovf_o, 1'b1);
    chk("sat_wide_data", dump_data_o, 32'd20);
    chk("sat_wide_ovf", dump_ovf_o, 1'b0);
    step();
    chk("sat_beat1_ovf", s_dump_ovf_o, 1'b0);
    repeat (3) step();
    chk("sat_done", s_dump_valid_o, 1'b0);
    cmd(CMD_CLEAR);
    cmd(CMD_DUMP);
    chk("clr_data", s_dump_data_o, 4'h0);
    chk("clr_ovf", s_dump_ovf_o, 1'b0);
    repeat (4) step();
    idle();

    // Dump while running with throttled readout; live count continues.
    do_reset();
    cmd(CMD_START);
    event_i = 16'h0001;
    repeat (5) step();
    cmd(CMD_DUMP);
    chk_beat("run_beat0", 2'd0, 32'd5, 1'b0);
    chk("run_dump_running", running_o, 1'b1);
    chk("run_dump_ready", cmd_ready_o, 1'b0);
    for (int i = 0; i < 8; i++) begin
      dump_ready_i = i[0];
      step();
      chk($sformatf("run_t%0d_running", i), running_o, 1'b1);
      if (i < 7) begin
        chk_beat($sformatf("run_t%0d", i), 2'((i + 1) / 2),
                 ((i + 1) / 2 == 0) ? 32'd5 : 32'd0, (i + 1) / 2 == 3);
      end else begin
        chk("run_end_valid", dump_valid_o, 1'b0);
        chk("run_end_ready", cmd_ready_o, 1'b1);
      end
    end
    dump_ready_i = 1'b0;
    cmd(CMD_STOP);
    event_i = '0;
    dump_ready_i = 1'b1;
    cmd(CMD_DUMP);
    chk_beat("run_live", 2'd0, 32'd15, 1'b0);
    repeat (4) step();
    idle();

    // Clear coinciding with a counted event.
    do_reset();
    cmd(CMD_START);
    event_i = 16'h0001;
    repeat (3) step();
    cmd(CMD_CLEAR);
    chk("clrev_running", running_o, 1'b1);
    event_i = '0;
    cmd(CMD_STOP);
    dump_ready_i = 1'b1;
    cmd(CMD_DUMP);
    chk_beat("clrev_beat0", 2'd0, 32'd0, 1'b0);
    repeat (4) step();
    idle();

    // Reset asserted during beat 2 aborts the stream at once.
    do_reset();
    cmd(CMD_START);
    event_i = 16'h0001;
    repeat (3) step();
    event_i = '0;
    cmd(CMD_STOP);
    dump_ready_i = 1'b1;
    cmd(CMD_DUMP);
    chk_beat("rmid_beat0", 2'd0, 32'd3, 1'b0);
    step();
    step();
    chk("rmid_beat2_idx", dump_idx_o, 2'd2);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rmid_valid", dump_valid_o, 1'b0);
    chk("rmid_ready", cmd_ready_o, 1'b1);
    chk("rmid_running", running_o, 1'b0);
    chk("rmid_idx", dump_idx_o, 2'd0);
    chk("rmid_data", dump_data_o, 32'd0);
    chk("rmid_last", dump_last_o, 1'b0);
    step();
    chk("rmid_hold_valid", dump_valid_o, 1'b0);
    rst_i = 1'b0;
    dump_ready_i = 1'b1;
    cmd(CMD_DUMP);
    for (int k = 0; k < 4; k++) begin
      chk_beat($sformatf("rmid_post%0d", k), 2'(k), 32'd0, k == 3);
      step();
    end
    chk("rmid_post_done", dump_valid_o, 1'b0);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
